exmem_pipe_chain: RTL and testbench

Parametrised multi-stage pipeline register for the CPU datapath, replacing fixed per-boundary latches between EX and MEM/WB. It carries a data word, a control bundle and a destination-register tag through DEPTH stages. Each stage has its own valid bit, and the chain supports global stall, flush and bubble insertion. An optional forwarding lookup lets the hazard unit source in-flight results without waiting for writeback.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_fwd_lookup.sv | 38 +++
 rtl/exmem_pipe_chain.sv | 143 ++++++++++++++
 tb/tb_exmem_pipe_chain.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the EX->MEM/WB pipeline register chain.
//   DEPTH_MAX       : largest supported chain depth
//   PIPE_*_W        : default payload widths for the datapath
//   stage_t         : one pipeline stage {valid, wr, dst, ctrl, data}
//   pipe_event_e    : per-cycle event after flush-over-stall resolution
//   pipe_event()    : resolves the flush/stall pair into a pipe_event_e
package pipe_pkg;

    localparam int DEPTH_MAX   = 4;
    localparam int PIPE_DATA_W = 8;
    localparam int PIPE_CTRL_W = 4;
    localparam int PIPE_REG_AW = 3;

    typedef struct packed {
        logic                   valid;
        logic                   wr;
        logic [PIPE_REG_AW-1:0] dst;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data;
    } stage_t;

    typedef enum logic [1:0] {
        EV_ADVANCE = 2'd0,
        EV_STALL   = 2'd1,
        EV_FLUSH   = 2'd2
    } pipe_event_e;

    // Flush always beats stall; advance only when neither is asserted.
    function automatic pipe_event_e pipe_event(input logic flush, input logic stall);
        if (flush) begin
            return EV_FLUSH;
        end
        if (stall) begin
            return EV_STALL;
        end
        return EV_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_fwd_lookup.sv
// pipe_fwd_lookup
// Youngest-first forwarding match over the in-flight stage tags.
// Ports:
//   valid, wr   : per-stage valid and register-write bits
//   dst, data   : per-stage destination tag and payload
//   addr        : lookup register address (address 0 never matches)
//   hit         : some valid writer targets addr
//   hit_data    : payload of the youngest matching stage, 0 on miss
module pipe_fwd_lookup
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int DEPTH  = 2
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [DEPTH-1:0]  wr,
    input  logic [REG_AW-1:0] dst  [DEPTH],
    input  logic [DATA_W-1:0] data [DEPTH],
    input  logic [REG_AW-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    // Stage 0 holds the youngest instruction, so the first match scanning
    // upward is the most recent producer of the register.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && valid[i] && wr[i] && (dst[i] == addr) && (addr != '0)) begin
                hit      = 1'b1;
                hit_data = data[i];
            end
        end
    end

endmodule

// File: rtl/exmem_pipe_chain.sv
// exmem_pipe_chain
// DEPTH-stage pipeline register between EX and MEM/WB with per-stage valid,
// global stall/flush and bubble insertion. Optional forwarding lookup is
// compiled in when EXMEM_PIPE_FWD_EN is defined.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_data/in_ctrl/
//   in_dst/in_wr                  : instruction offered to stage 0
//   stall, flush                  : hold all stages / invalidate all stages
//   out_valid/out_data/out_ctrl/
//   out_dst/out_wr                : contents of stage DEPTH-1
//   occ                           : registered count of valid stages
//   lk_addr, lk_hit, lk_data      : forwarding lookup (EXMEM_PIPE_FWD_EN)
// Legal DEPTH range is 1..DEPTH_MAX.
module exmem_pipe_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [REG_AW-1:0]          in_dst,
    input  logic                       in_wr,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [REG_AW-1:0]          out_dst,
    output logic                       out_wr,
    output logic [$clog2(DEPTH+1)-1:0] occ
`ifdef EXMEM_PIPE_FWD_EN
    ,
    input  logic [REG_AW-1:0]          lk_addr,
    output logic                       lk_hit,
    output logic [DATA_W-1:0]          lk_data
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  wr_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [REG_AW-1:0] dst_q  [DEPTH];
    logic [OCC_W-1:0]  occ_d;
    pipe_event_e       ev;

    assign ev = pipe_event(flush, stall);

    always_comb begin
        valid_d = valid_q;
        case (ev)
            EV_FLUSH: valid_d = '0;
            EV_ADVANCE: begin
                for (int i = DEPTH-1; i > 0; i--) begin
                    valid_d[i] = valid_q[i-1];
                end
                valid_d[0] = in_valid;
            end
            default: ;
        endcase
    end

    // occ is registered from the next-state valid bits so it changes on the
    // same edge as the stages it counts.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            wr_q    <= '0;
            occ     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= '0;
                dst_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ     <= occ_d;
            case (ev)
                // data/dst are left as-is on flush; only the qualifying
                // fields are cleared so the stage reads as an empty slot.
                EV_FLUSH: begin
                    wr_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        ctrl_q[i] <= '0;
                    end
                end
                EV_ADVANCE: begin
                    for (int i = DEPTH-1; i > 0; i--) begin
                        data_q[i] <= data_q[i-1];
                        ctrl_q[i] <= ctrl_q[i-1];
                        dst_q[i]  <= dst_q[i-1];
                        wr_q[i]   <= wr_q[i-1];
                    end
                    data_q[0] <= in_data;
                    dst_q[0]  <= in_dst;
                    ctrl_q[0] <= in_valid ? in_ctrl : '0;
                    wr_q[0]   <= in_valid & in_wr;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_dst   = dst_q[DEPTH-1];
    assign out_ctrl  = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign out_wr    = wr_q[DEPTH-1] & valid_q[DEPTH-1];

`ifdef EXMEM_PIPE_FWD_EN
    pipe_fwd_lookup #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fwd_lookup (
        .valid    (valid_q),
        .wr       (wr_q),
        .dst      (dst_q),
        .data     (data_q),
        .addr     (lk_addr),
        .hit      (lk_hit),
        .hit_data (lk_data)
    );
`endif

endmodule

// File: tb/tb_exmem_pipe_chain.sv
module tb_exmem_pipe_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_wr, stall, flush;
    logic [7:0] in_data;
    logic [3:0] in_ctrl;
    logic [2:0] in_dst;

    logic       o2_valid, o2_wr, o3_valid, o3_wr;
    logic [7:0] o2_data, o3_data;
    logic [3:0] o2_ctrl, o3_ctrl;
    logic [2:0] o2_dst, o3_dst;
    logic [1:0] o2_occ, o3_occ;

`ifdef EXMEM_PIPE_FWD_EN
    logic [2:0] lk_addr;
    logic       lk2_hit, lk3_hit;
    logic [7:0] lk2_data, lk3_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exmem_pipe_chain #(.DATA_W(8), .CTRL_W(4), .REG_AW(3), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wr(in_wr), .stall(stall),
        .flush(flush), .out_valid(o2_valid), .out_data(o2_data),
        .out_ctrl(o2_ctrl), .out_dst(o2_dst), .out_wr(o2_wr), .occ(o2_occ)
`ifdef EXMEM_PIPE_FWD_EN
        , .lk_addr(lk_addr), .lk_hit(lk2_hit), .lk_data(lk2_data)
`endif
    );

    exmem_pipe_chain #(.DATA_W(8), .CTRL_W(4), .REG_AW(3), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_dst(in_dst), .in_wr(in_wr), .stall(stall),
        .flush(flush), .out_valid(o3_valid), .out_data(o3_data),
        .out_ctrl(o3_ctrl), .out_dst(o3_dst), .out_wr(o3_wr), .occ(o3_occ)
`ifdef EXMEM_PIPE_FWD_EN
        , .lk_addr(lk_addr), .lk_hit(lk3_hit), .lk_data(lk3_data)
`endif
    );

    // Reference model: one record per stage, index 0 = youngest.
    typedef struct {
        logic       v;
        logic       w;
        logic [2:0] dst;
        logic [3:0] c;
        logic [7:0] d;
    } slot_t;

    slot_t mdl [2][4];
    int    mdepth [2] = '{2, 3};

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] c;
        logic [2:0] dst;
        logic       w;
        logic       st;
        logic       fl;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] ec;
        logic       ew;
        logic [1:0] eo;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                mdl[k][i].v   = 1'b0;
                mdl[k][i].w   = 1'b0;
                mdl[k][i].dst = 3'd0;
                mdl[k][i].c   = 4'd0;
                mdl[k][i].d   = 8'd0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] c,
                         input logic [2:0] dst, input logic w, input logic st, input logic fl);
        in_valid = v; in_data = d; in_ctrl = c; in_dst = dst; in_wr = w;
        stall = st; flush = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                for (int i = 0; i < mdepth[k]; i++) begin
                    mdl[k][i].v = 1'b0;
                    mdl[k][i].c = 4'd0;
                    mdl[k][i].w = 1'b0;
                end
            end else if (!stall) begin
                for (int i = mdepth[k]-1; i > 0; i--) begin
                    mdl[k][i] = mdl[k][i-1];
                end
                mdl[k][0].v   = in_valid;
                mdl[k][0].w   = in_valid & in_wr;
                mdl[k][0].dst = in_dst;
                mdl[k][0].c   = in_valid ? in_ctrl : 4'd0;
                mdl[k][0].d   = in_data;
            end
        end
    endtask

    task automatic check_one(input int k, input string tag, input logic v, input logic [7:0] d,
                             input logic [3:0] c, input logic [2:0] dst, input logic w,
                             input logic [1:0] occ);
        slot_t last;
        int    cnt;
        last = mdl[k][mdepth[k]-1];
        cnt  = 0;
        for (int i = 0; i < mdepth[k]; i++) begin
            if (mdl[k][i].v) cnt++;
        end
        chk({tag, "_valid"}, 32'(v), 32'(last.v));
        chk({tag, "_data"}, 32'(d), 32'(last.d));
        chk({tag, "_ctrl"}, 32'(c), last.v ? 32'(last.c) : 32'd0);
        chk({tag, "_dst"}, 32'(dst), 32'(last.dst));
        chk({tag, "_wr"}, 32'(w), 32'(last.w & last.v));
        chk({tag, "_occ"}, 32'(occ), 32'(cnt));
    endtask

    task automatic check_model();
        check_one(0, "rnd_d2", o2_valid, o2_data, o2_ctrl, o2_dst, o2_wr, o2_occ);
        check_one(1, "rnd_d3", o3_valid, o3_data, o3_ctrl, o3_dst, o3_wr, o3_occ);
    endtask

`ifdef EXMEM_PIPE_FWD_EN
    function automatic logic [8:0] ref_lookup(input int k, input logic [2:0] a);
        for (int i = 0; i < mdepth[k]; i++) begin
            if (mdl[k][i].v && mdl[k][i].w && mdl[k][i].dst == a && a != 3'd0)
                return {1'b1, mdl[k][i].d};
        end
        return 9'd0;
    endfunction
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef EXMEM_PIPE_FWD_EN
        lk_addr = 3'd0;
`endif
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("por_valid", 32'(o2_valid), 32'd0);
        chk("por_occ", 32'(o2_occ), 32'd0);
        do_reset();

        // ---- mid-clock reset, then accept 0x5A ----
        drive(1'b1, 8'h99, 4'h7, 3'd5, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("pre_rst_valid", 32'(o2_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o2_valid), 32'd0);
        chk("rst_async_data", 32'(o2_data), 32'd0);
        chk("rst_async_ctrl", 32'(o2_ctrl), 32'd0);
        chk("rst_async_wr", 32'(o2_wr), 32'd0);
        chk("rst_async_occ", 32'(o2_occ), 32'd0);
        drive(1'b1, 8'h5A, 4'hF, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk("rst_held_valid", 32'(o2_valid), 32'd0);
        chk("rst_held_occ", 32'(o2_occ), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("acc1_occ", 32'(o2_occ), 32'd1);
        chk("acc1_valid", 32'(o2_valid), 32'd0);
        step();
        chk("acc2_valid", 32'(o2_valid), 32'd1);
        chk("acc2_data", 32'(o2_data), 32'h5A);
        chk("acc2_ctrl", 32'(o2_ctrl), 32'hF);
        chk("acc2_wr", 32'(o2_wr), 32'd1);
        chk("acc2_occ", 32'(o2_occ), 32'd2);

        // ---- stall hold ----
        do_reset();
        drive(1'b1, 8'h11, 4'h1, 3'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h22, 4'h2, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h33, 4'h3, 3'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", 32'(o2_data), 32'h11);
            chk("stall_occ", 32'(o2_occ), 32'd2);
        end
        drive(1'b0, 8'h33, 4'h3, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk("unstall_data", 32'(o2_data), 32'h22);
        chk("unstall_valid", 32'(o2_valid), 32'd1);
        step();
        chk("stall_drop_valid", 32'(o2_valid), 32'd0);
        chk("stall_drop_occ", 32'(o2_occ), 32'd0);

        // ---- table: bubble, flush priority, data retention (DEPTH=2) ----
        tbl[0] = '{1'b1, 8'h11, 4'h3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd1};
        tbl[1] = '{1'b1, 8'h22, 4'h5, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'h3, 1'b1, 2'd2};
        tbl[2] = '{1'b1, 8'h33, 4'h8, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 4'h3, 1'b1, 2'd2};
        tbl[3] = '{1'b0, 8'h44, 4'hF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'h5, 1'b1, 2'd1};
        tbl[4] = '{1'b1, 8'h55, 4'h6, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 4'h0, 1'b0, 2'd1};
        tbl[5] = '{1'b1, 8'h66, 4'h7, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 4'h0, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 8'h77, 4'h9, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 4'h0, 1'b0, 2'd1};
        tbl[7] = '{1'b1, 8'h88, 4'hA, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 4'h0, 1'b0, 2'd0};
        do_reset();
        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].v, tbl[r].d, tbl[r].c, tbl[r].dst, tbl[r].w, tbl[r].st, tbl[r].fl);
            step();
            chk($sformatf("tbl%0d_valid", r), 32'(o2_valid), 32'(tbl[r].ev));
            chk($sformatf("tbl%0d_data", r), 32'(o2_data), 32'(tbl[r].ed));
            chk($sformatf("tbl%0d_ctrl", r), 32'(o2_ctrl), 32'(tbl[r].ec));
            chk($sformatf("tbl%0d_wr", r), 32'(o2_wr), 32'(tbl[r].ew));
            chk($sformatf("tbl%0d_occ", r), 32'(o2_occ), 32'(tbl[r].eo));
        end

`ifdef EXMEM_PIPE_FWD_EN
        // ---- forwarding, DEPTH=3 ----
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            drive(1'b1, 8'hBB, 4'h1, 3'd3, 1'b1, 1'b0, 1'b0);
            step();
            drive(1'b1, 8'h01, 4'h2, 3'd1, 1'b1, 1'b0, 1'b0);
            step();
            drive(1'b1, 8'hAA, 4'h3, 3'd3, (pass == 0), 1'b0, 1'b0);
            step();
            drive(1'b0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0);
            lk_addr = 3'd3;
            #1;
            chk("fwd3_hit", 32'(lk3_hit), 32'd1);
            chk("fwd3_data", 32'(lk3_data), (pass == 0) ? 32'hAA : 32'hBB);
            lk_addr = 3'd0;
            #1;
            chk("fwd0_hit", 32'(lk3_hit), 32'd0);
            chk("fwd0_data", 32'(lk3_data), 32'd0);
            lk_addr = 3'd1;
            #1;
            chk("fwd1_data", 32'(lk3_data), 32'h01);
            lk_addr = 3'd5;
            #1;
            chk("fwd5_hit", 32'(lk3_hit), 32'd0);
        end
`endif

        // ---- randomized against model, with one mid-stream reset ----
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 11) == 0));
`ifdef EXMEM_PIPE_FWD_EN
            lk_addr = 3'($urandom_range(0, 7));
            #1;
            begin
                logic [8:0] e3, e2;
                e3 = ref_lookup(1, lk_addr);
                e2 = ref_lookup(0, lk_addr);
                chk("rnd_lk3", {23'd0, lk3_hit, lk3_data}, 32'(e3));
                chk("rnd_lk2", {23'd0, lk2_hit, lk2_data}, 32'(e2));
            end
`endif
            model_edge();
            step();
            check_model();
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_clear();
                check_model();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
